// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver behind a 2-register CPU port; byte lands ~3 clk after stop-bit centre, bus reads take 1 clk.
// No backpressure on the line: an unread byte blocks delivery and sets overrun. UART_RX_FIFO_EN swaps hold reg for 4-deep FIFO.
module uart_rx #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] dbr_o,
  input  logic [7:0] dbw_i,
  input  logic       addr_i,
  input  logic       we_i,
  input  logic       re_i,
  input  logic       rx_i,
  output logic       irq_o
);

  localparam int BIT_DIV  = CLK_HZ / BAUD;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int CW       = $clog2(BIT_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_meta_q, rx_s_q;

  logic          bit_tick;
  logic          shift_en;
  logic          deliver;
  logic          ferr_set;

  logic          pop, stat_rd, flag_wr;
  logic          ready, pop_ok, push_ok, lost;
  logic [7:0]    rd_byte;
  logic          busy;

  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    dbr_q, dbr_d;

  logic          unused_dbw;
  assign unused_dbw = ^{dbw_i[7], dbw_i[4:0]};

  // Sync flops reset high so an idle line never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (cnt_q == HALF_LAST) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_q == BIT_LAST && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (cnt_q == BIT_LAST) state_d = rx_s_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_tick = (cnt_q == BIT_LAST);
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_DATA: shift_en = bit_tick;
      S_STOP: begin
        deliver  = bit_tick & rx_s_q;
        ferr_set = bit_tick & ~rx_s_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_d != state_q || shift_en || state_q == S_IDLE || state_q == S_WAIT) begin
      cnt_d = '0;
    end
    if (state_q != S_DATA) begin
      bit_d = 3'd0;
    end
    if (shift_en) begin
      shreg_d = {rx_s_q, shreg_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  assign pop     = re_i & ~addr_i;
  assign stat_rd = re_i & addr_i;
  assign flag_wr = we_i & addr_i;
  assign busy    = (state_q != S_IDLE);

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q, count_d;
  logic [7:0] last_q;

  assign ready   = (count_q != 3'd0);
  assign pop_ok  = pop & ready;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push_ok = deliver & ((count_q != 3'd4) | pop_ok);
  assign lost    = deliver & ~push_ok;
  assign rd_byte = pop_ok ? fifo_q[rd_ptr_q] : last_q;

  always_comb begin
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      last_q   <= 8'h00;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        last_q   <= fifo_q[rd_ptr_q];
      end
    end
  end
`else
  logic       ready_q, ready_d;
  logic [7:0] hold_q, hold_d;

  assign ready   = ready_q;
  assign pop_ok  = pop & ready_q;
  assign push_ok = deliver & (~ready_q | pop_ok);
  assign lost    = deliver & ~push_ok;
  assign rd_byte = hold_q;

  always_comb begin
    ready_d = ready_q;
    hold_d  = hold_q;
    if (push_ok) begin
      ready_d = 1'b1;
      hold_d  = shreg_q;
    end else if (pop_ok) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      ready_q <= ready_d;
      hold_q  <= hold_d;
    end
  end
`endif

  // Clear and set on the same edge: the set term is OR'd last so it wins.
  always_comb begin
    overrun_d   = (overrun_q & ~(flag_wr & dbw_i[6])) | lost;
    frame_err_d = (frame_err_q & ~(flag_wr & dbw_i[5])) | ferr_set;
    dbr_d       = dbr_q;
    if (pop) begin
      dbr_d = rd_byte;
    end else if (stat_rd) begin
      dbr_d = {ready, overrun_q, frame_err_q, busy, 4'b0000};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      dbr_q       <= 8'h00;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      dbr_q       <= dbr_d;
    end
  end

  assign dbr_o = dbr_q;
  assign irq_o = ready;

endmodule
